// File: rtl/pcie_lcrc_stream.sv
// Streaming PCIe LCRC engine: folds a framed byte stream into CRC-32 and
// returns the complemented, per-byte bit-reversed LCRC through a valid/ready port.
module pcie_lcrc_stream #(
  parameter int          DATA_BYTES = 2,
  parameter logic [31:0] POLY       = 32'h04C1_1DB7,
  parameter logic [31:0] SEED       = 32'hFFFF_FFFF,
  parameter bit          INVERT_OUT = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 in_sop,
  input  logic                                 in_eop,
  input  logic [8*DATA_BYTES-1:0]              in_data,
  input  logic [$clog2(DATA_BYTES+1)-1:0]      in_nbytes,
  output logic                                 crc_valid,
  input  logic                                 crc_ready,
  output logic [31:0]                          crc_out,
  output logic                                 busy,
  output logic                                 err_proto
);

  localparam int NBW = $clog2(DATA_BYTES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_e;

  // Bytes fold in order 0..n-1, each byte LSB first into an MSB-first shift register.
  function automatic logic [31:0] crc_fold(input logic [31:0] crc_in,
                                           input logic [8*DATA_BYTES-1:0] data,
                                           input logic [NBW-1:0] nbytes);
    logic [31:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (i < int'(nbytes)) begin
        for (int j = 0; j < 8; j++) begin
          fb = c[31] ^ data[8*i+j];
          c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0000_0000);
        end
      end
    end
    return c;
  endfunction

  function automatic logic [31:0] lcrc_order(input logic [31:0] c);
    logic [31:0] r;
    logic [31:0] o;
    r = INVERT_OUT ? ~c : c;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 8; j++) begin
        o[8*k+7-j] = r[8*k+j];
      end
    end
    return o;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] crc_out_q, crc_out_d;
  logic        err_q, err_d;
  logic        accept_s;
  logic        nb_over_s;
  logic [NBW-1:0] eff_nbytes_s;
  logic [31:0] start_s;
  logic [31:0] folded_s;

  assign in_ready  = (state_q != HOLD);
  assign busy      = (state_q != IDLE);
  assign crc_valid = (state_q == HOLD);
  assign crc_out   = crc_out_q;
  assign err_proto = err_q;

  assign accept_s  = in_valid && in_ready;
  assign nb_over_s = in_eop && (int'(in_nbytes) > DATA_BYTES);
  assign eff_nbytes_s = (!in_eop || (in_nbytes == {NBW{1'b0}}) || nb_over_s)
                        ? NBW'(DATA_BYTES) : in_nbytes;
  // A sop beat always restarts from SEED, even when it aborts a frame in progress.
  assign start_s  = ((state_q == ACCUM) && !in_sop) ? crc_q : SEED;
  assign folded_s = crc_fold(start_s, in_data, eff_nbytes_s);

  // Next-state, CRC register and error pulse for the current beat.
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    crc_out_d = crc_out_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s && in_sop) begin
          crc_d = folded_s;
          err_d = nb_over_s;
          if (in_eop) begin
            state_d   = HOLD;
            crc_out_d = lcrc_order(folded_s);
          end else begin
            state_d = ACCUM;
          end
        end else if (accept_s) begin
          err_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (accept_s) begin
          crc_d = folded_s;
          err_d = in_sop || nb_over_s;
          if (in_eop) begin
            state_d   = HOLD;
            crc_out_d = lcrc_order(folded_s);
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      HOLD: begin
        if (crc_ready) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      crc_q     <= SEED;
      crc_out_q <= 32'h0000_0000;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      crc_out_q <= crc_out_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_pcie_lcrc_stream.sv
// Scoreboard bench for pcie_lcrc_stream: reflected CRC-32 reference model,
// directed framing cases, random frames with random result backpressure.
module tb_pcie_lcrc_stream;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid, in_ready, in_sop, in_eop;
  logic [15:0] in_data;
  logic [1:0]  in_nbytes;
  logic        crc_valid, crc_ready, busy, err_proto;
  logic [31:0] crc_out;

  int          n_pass = 0;
  int          n_total = 0;
  int          err_cnt = 0;
  logic [31:0] exp_q[$];
  bit          hold_prev = 1'b0;
  logic [31:0] held;
  bit          rand_ready_en = 1'b0;

  always #5 clk = ~clk;

  pcie_lcrc_stream #(.DATA_BYTES(2)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data), .in_nbytes(in_nbytes),
    .crc_valid(crc_valid), .crc_ready(crc_ready), .crc_out(crc_out),
    .busy(busy), .err_proto(err_proto)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, want %b", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_total++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Standard reflected CRC-32; the LCRC on the wire is its byte-swapped form.
  function automatic logic [31:0] ref_lcrc(input byte unsigned b[$]);
    logic [31:0] c;
    logic [31:0] s;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    s = ~c;
    return {s[7:0], s[15:8], s[23:16], s[31:24]};
  endfunction

  task automatic send_beat(input bit sop, input bit eop, input logic [15:0] data, input logic [1:0] nb);
    int t;
    in_valid = 1'b1; in_sop = sop; in_eop = eop; in_data = data; in_nbytes = nb;
    t = 0;
    while (!in_ready && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 300) timeout("in_ready_wait");
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic send_frame(input byte unsigned b[$], input bit push);
    int n, beats, rem;
    logic [15:0] d;
    logic [1:0]  nb;
    n = b.size();
    beats = (n + 1) / 2;
    for (int bi = 0; bi < beats; bi++) begin
      d = 16'($urandom);
      rem = n - 2 * bi;
      d[7:0] = b[2*bi];
      if (rem >= 2) d[15:8] = b[2*bi+1];
      if (bi == beats - 1) begin
        if (rem >= 2) nb = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd2;
        else nb = 2'd1;
        if (push) exp_q.push_back(ref_lcrc(b));
      end else begin
        nb = 2'($urandom);
      end
      send_beat(bi == 0, bi == beats - 1, d, nb);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 300) timeout("idle_wait");
  endtask

  // Monitor: scoreboard pops on each handshake, held results must not move.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (err_proto) err_cnt++;
      if (hold_prev) begin
        check_bit("hold_valid", crc_valid, 1'b1);
        check("hold_stable", crc_out, held);
      end
      if (crc_valid && crc_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_result: got %h, none expected", crc_out);
        end else begin
          check("result", crc_out, exp_q.pop_front());
        end
      end
      hold_prev = crc_valid && !crc_ready;
      held = crc_out;
    end
  end

  initial forever begin
    @(posedge clk); #2;
    if (rand_ready_en) crc_ready = ($urandom_range(0, 3) != 0);
  end

  // Narrow and wide instances run the reference frame plus random frames.
  for (genvar g = 0; g < 2; g++) begin : g_w
    localparam int W = (g == 0) ? 1 : 4;
    localparam int NBW = $clog2(W + 1);
    logic           v, s, e, rdy, cv, er, bs;
    logic [8*W-1:0] d;
    logic [NBW-1:0] nb;
    logic [31:0]    co;
    logic           sub_reset = 1'b1;
    logic [31:0]    q[$];
    bit             done = 1'b0;

    pcie_lcrc_stream #(.DATA_BYTES(W)) u_dut (
      .clk(clk), .reset(sub_reset), .in_valid(v), .in_ready(rdy),
      .in_sop(s), .in_eop(e), .in_data(d), .in_nbytes(nb),
      .crc_valid(cv), .crc_ready(1'b1), .crc_out(co),
      .busy(bs), .err_proto(er)
    );

    initial forever begin
      @(negedge clk);
      if (!sub_reset && cv) begin
        check_bit($sformatf("w%0d_no_err", W), er, 1'b0);
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL w%0d_unexpected_result: got %h, none expected", W, co);
        end else begin
          check($sformatf("w%0d_result", W), co, q.pop_front());
        end
      end
    end

    initial begin
      byte unsigned b[$];
      int n, beats, rem, idx, t;
      v = 1'b0; s = 1'b0; e = 1'b0; d = '0; nb = '0;
      repeat (3) @(posedge clk);
      #1 sub_reset = 1'b0;
      for (int f = 0; f < 4; f++) begin
        b.delete();
        if (f == 0) for (int i = 0; i < 9; i++) b.push_back(8'(8'h31 + i));
        else begin
          n = $urandom_range(1, 13);
          for (int i = 0; i < n; i++) b.push_back(8'($urandom));
        end
        n = b.size();
        beats = (n + W - 1) / W;
        for (int bi = 0; bi < beats; bi++) begin
          for (int i = 0; i < W; i++) begin
            idx = bi * W + i;
            d[8*i +: 8] = (idx < n) ? b[idx] : 8'($urandom);
          end
          rem = n - bi * W;
          s = (bi == 0);
          e = (bi == beats - 1);
          if (e) begin
            nb = (rem >= W) ? NBW'(0) : NBW'(rem);
            q.push_back(ref_lcrc(b));
          end else begin
            nb = NBW'($urandom);
          end
          v = 1'b1;
          t = 0;
          while (!rdy && t < 300) begin
            @(posedge clk); #1;
            t++;
          end
          if (t >= 300) timeout($sformatf("w%0d_in_ready_wait", W));
          @(posedge clk); #1;
          v = 1'b0;
        end
      end
      t = 0;
      while ((q.size() != 0 || cv) && t < 300) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= 300) timeout($sformatf("w%0d_drain", W));
      done = 1'b1;
    end
  end

  initial begin
    byte unsigned nine[$];
    byte unsigned b[$];
    int e0, n, t;
    logic [15:0] r16;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = 16'h0000; in_nbytes = 2'd0;
    crc_ready = 1'b1;
    for (int i = 0; i < 9; i++) nine.push_back(8'(8'h31 + i));

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_bit("rst_crc_valid", crc_valid, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_err", err_proto, 1'b0);
    check_bit("rst_in_ready", in_ready, 1'b1);
    check("rst_crc_out", crc_out, 32'h0000_0000);
    @(posedge clk); #1 reset = 1'b0;

    send_frame(nine, 1'b1);
    check_bit("latency_valid", crc_valid, 1'b1);
    check("check_123456789", crc_out, 32'h2639_F4CB);
    @(posedge clk); #1;
    check_bit("after_handshake_valid", crc_valid, 1'b0);

    exp_q.push_back(32'h8DEF_02D2);
    send_beat(1'b1, 1'b1, 16'h0000, 2'd1);
    exp_q.push_back(32'h8DEF_02D2);
    send_beat(1'b1, 1'b1, 16'hFF00, 2'd1);
    wait_idle();

    crc_ready = 1'b0;
    send_frame(nine, 1'b1);
    in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b1; in_data = 16'h0000; in_nbytes = 2'd1;
    repeat (5) begin
      @(posedge clk); #1;
      check_bit("bp_valid", crc_valid, 1'b1);
      check_bit("bp_in_ready", in_ready, 1'b0);
      check("bp_out", crc_out, 32'h2639_F4CB);
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    crc_ready = 1'b1;
    @(posedge clk); #1;
    check_bit("bp_release_in_ready", in_ready, 1'b1);
    check_bit("bp_release_valid", crc_valid, 1'b0);

    e0 = err_cnt;
    send_beat(1'b1, 1'b0, 16'($urandom), 2'd0);
    send_beat(1'b0, 1'b0, 16'($urandom), 2'd0);
    send_beat(1'b0, 1'b0, 16'($urandom), 2'd0);
    send_frame(nine, 1'b1);
    wait_idle();
    check("abort_err_pulses", 32'(err_cnt - e0), 32'd1);

    e0 = err_cnt;
    send_beat(1'b0, 1'b1, 16'h1234, 2'd2);
    @(posedge clk); #1;
    check("nosop_err_pulses", 32'(err_cnt - e0), 32'd1);
    check_bit("nosop_busy", busy, 1'b0);
    check_bit("nosop_valid", crc_valid, 1'b0);

    send_beat(1'b1, 1'b0, 16'($urandom), 2'd0);
    send_beat(1'b0, 1'b0, 16'($urandom), 2'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_bit("midreset_busy", busy, 1'b0);
    check_bit("midreset_valid", crc_valid, 1'b0);
    reset = 1'b0;
    send_frame(nine, 1'b1);
    wait_idle();

    e0 = err_cnt;
    b.delete();
    for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
    exp_q.push_back(ref_lcrc(b));
    send_beat(1'b1, 1'b0, {b[1], b[0]}, 2'd0);
    send_beat(1'b0, 1'b1, {b[3], b[2]}, 2'd3);
    wait_idle();
    check("nbytes_over_err", 32'(err_cnt - e0), 32'd1);

    e0 = err_cnt;
    rand_ready_en = 1'b1;
    for (int f = 0; f < 40; f++) begin
      b.delete();
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      send_frame(b, 1'b1);
    end
    rand_ready_en = 1'b0;
    @(posedge clk); #1;
    crc_ready = 1'b1;
    t = 0;
    while ((exp_q.size() != 0 || crc_valid) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 500) timeout("drain");
    check("random_no_err", 32'(err_cnt - e0), 32'd0);

    t = 0;
    while (!(g_w[0].done && g_w[1].done) && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 5000) timeout("width_variants");

    r16 = 16'(exp_q.size());
    check("queue_empty", {16'h0, r16}, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pcie_lcrc_stream.md
Name: pcie_lcrc_stream

Overview:
Parameterised streaming CRC-32 engine that computes the PCIe Data Link Layer LCRC over a framed byte stream, any number of bytes per beat.
- Sits between the DLL sequence-number prepender and the transmit framer.
- Accumulates the CRC across multi-beat TLPs using sop/eop framing and a partial-last-beat byte count.
- Presents the final complemented, PCIe bit-ordered LCRC through a valid/ready result port with backpressure.

Parameters:
DATA_BYTES, 2, bytes per input beat (1..16); in_data width is 8*DATA_BYTES.
POLY, 32'h04C1_1DB7, generator polynomial (normal form, x^32 implicit).
SEED, 32'hFFFF_FFFF, CRC register value loaded at each sop.
INVERT_OUT, 1, 1 = complement the register before output ordering; 0 = raw.

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  input beat valid
in_ready  output  1  engine accepts a beat when in_valid && in_ready
in_sop  input  1  first beat of frame
in_eop  input  1  last beat of frame
in_data  input  8*DATA_BYTES  byte 0 = in_data[7:0], processed first
in_nbytes  input  $clog2(DATA_BYTES+1)  valid bytes on eop beat (low bytes); 0 means DATA_BYTES; ignored if !in_eop
crc_valid  output  1  result available
crc_ready  input  1  result consumer ready
crc_out  output  32  final LCRC
busy  output  1  frame in progress or result pending
err_proto  output  1  one-cycle pulse on framing violation

Behaviour:
- Reset is synchronous, active-high, clock clk. Reset values: state IDLE, crc register = SEED, crc_valid 0, crc_out 0, err_proto 0, busy 0. in_ready is 1 after reset.
- Reset asserted mid-frame or while a result is held discards everything. No result is emitted for that frame.
- States:
  - IDLE: waiting for sop.
  - ACCUM: frame in progress.
  - HOLD: result valid, waiting for crc_ready.
- in_ready = (state != HOLD). It is combinational from state only.
- Bit update, per bit b:
  - fb = crc[31] ^ b
  - crc = {crc[30:0],0} ^ (fb ? POLY : 0)
- Bytes are processed in order 0..n-1. Within a byte, bits go LSB first (bit 0 first).
- All bytes of an accepted beat are folded in one cycle (unrolled combinational chain).
- Starting value for an sop beat is SEED, not the current register.
- Only bytes below the effective nbytes are folded on an eop beat.
- Transitions:
  - IDLE, accepted sop && !eop: fold, go to ACCUM.
  - IDLE, accepted sop && eop: fold, go to HOLD.
  - IDLE, accepted beat without sop: dropped, err_proto pulses, stay in IDLE.
  - ACCUM, accepted !sop && !eop: fold, stay in ACCUM.
  - ACCUM, accepted eop: fold, go to HOLD.
  - ACCUM, accepted sop: err_proto pulses. The frame restarts from SEED with this beat; sop && eop in the same beat goes to HOLD.
  - HOLD: crc_valid = 1. crc_out is held stable until crc_valid && crc_ready, then go to IDLE on the next edge.
- Latency: crc_valid rises on the edge after the eop beat is accepted (1 cycle).
- Back-to-back frames: the earliest next sop is accepted in the cycle after the result handshake.
- Output ordering:
  - Let r = INVERT_OUT ? ~crc : crc.
  - crc_out[8k+7-j] = r[8k+j] for k = 0..3, j = 0..7 (bit reversal within each byte, byte order kept).
  - crc_out is registered at eop and only changes then.
- busy = (state != IDLE).
- Width rules:
  - in_nbytes > DATA_BYTES on eop: treated as DATA_BYTES and err_proto pulses.
  - Upper bytes of a partial beat are don't-care and must not affect the result.

Test Plan:
- DATA_BYTES=2, frame "123456789" (0x31..0x39) as 5 beats, last with in_nbytes=1, crc_ready=1 -> crc_valid one cycle after eop, crc_out = 32'h2639_F4CB (byteswap of the standard CRC-32 0xCBF43926).
- Single beat, sop && eop, in_data = 16'hxx00, in_nbytes=1 -> crc_out = 32'h8DEF_02D2. Repeating with upper byte 0xFF gives the identical result.
- Hold crc_ready=0 for 5 cycles after the "123456789" result -> crc_valid and crc_out stable, in_ready=0 and incoming beats not consumed. Raise crc_ready -> in_ready=1 next cycle.
- Abort: 3 beats of a frame, then a new sop beat with the "123456789" data -> err_proto pulses once. Final result = 32'h2639_F4CB.
- Beat with in_valid and no sop in IDLE -> err_proto pulse, no state change, crc_valid stays 0.
- Reset asserted mid-frame, then "123456789" sent -> correct 32'h2639_F4CB. Repeat the CRC checks with DATA_BYTES=1 and DATA_BYTES=4 (in_nbytes=1 on the last beat) -> same result.
